// File: rtl/acquisition_sequencer.sv
// acquisition_sequencer: aligns multi-shot BRAM capture to the free-running address wrap,
// driving write enable/address for one full pass per shot with first/last pass flags.
module acquisition_sequencer #(
    parameter int BRAM_WIDTH = 13,
    parameter int SHOT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SHOT_WIDTH-1:0] n_shots,
    input  logic [BRAM_WIDTH-1:0] address,
    output logic                  wen,
    output logic [BRAM_WIDTH-1:0] count,
    output logic                  first_pass,
    output logic                  last_pass,
    output logic                  busy,
    output logic                  done,
    output logic [SHOT_WIDTH-1:0] shots_done
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
    state_t                r_state, w_state_nxt;
    logic [BRAM_WIDTH-1:0] r_count, w_count_nxt;
    logic [SHOT_WIDTH-1:0] r_shots, w_shots_nxt, r_target, w_target_nxt;
    logic [SHOT_WIDTH:0]   w_shots_inc;
    logic                  w_last_shot;
    assign w_shots_inc = {1'b0, r_shots} + (SHOT_WIDTH+1)'(1);
    assign w_last_shot = w_shots_inc == {1'b0, r_target};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_shots  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_shots  <= w_shots_nxt;
            r_target <= w_target_nxt;
        end
    end
    // Abort takes priority everywhere, so a pass interrupted on its last write is not counted.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = '0;
        w_shots_nxt  = r_shots;
        w_target_nxt = r_target;
        case (r_state)
            IDLE: if (start && !abort) begin
                w_state_nxt  = ARM;
                w_target_nxt = (n_shots == '0) ? SHOT_WIDTH'(1) : n_shots;
                w_shots_nxt  = '0;
            end
            ARM: w_state_nxt = abort ? IDLE : (address == '1) ? CAPTURE : ARM;
            CAPTURE: if (abort) begin
                w_state_nxt = IDLE;
            end else begin
                w_count_nxt = r_count + BRAM_WIDTH'(1);
                if (r_count == '1) begin
                    w_shots_nxt = (r_shots < r_target) ? w_shots_inc[SHOT_WIDTH-1:0] : r_shots;
                    w_state_nxt = w_last_shot ? DONE : CAPTURE;
                end
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    assign wen        = r_state == CAPTURE;
    assign count      = r_count;
    assign first_pass = wen && (r_shots == '0);
    assign last_pass  = wen && w_last_shot;
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    assign shots_done = r_shots;
endmodule

// File: tb/tb_acquisition_sequencer.sv
// tb_acquisition_sequencer: directed and random stimulus against a pass-position
// reference model (expected outputs derived from cycles elapsed since capture start).
module tb_acquisition_sequencer;
    localparam int BW = 4;
    localparam int SW = 4;
    localparam int P  = 1 << BW;

    logic          clk = 0, rst = 1, start = 0, abort = 0;
    logic [SW-1:0] n_shots = '0;
    logic [BW-1:0] address = '0;
    logic          wen, first_pass, last_pass, busy, done;
    logic [BW-1:0] count;
    logic [SW-1:0] shots_done;

    int n_chk = 0, n_err = 0, e = 0;
    bit m_act = 0;
    int m_cs = -1, m_tgt = 0, m_sd = 0;

    acquisition_sequencer #(.BRAM_WIDTH(BW), .SHOT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_shots(n_shots),
        .address(address), .wen(wen), .count(count), .first_pass(first_pass),
        .last_pass(last_pass), .busy(busy), .done(done), .shots_done(shots_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, e, act, exp);
        end
    endtask

    // One clock: inputs are sampled at the posedge, the model advances, outputs checked at negedge.
    task automatic step(input logic st, input logic ab, input logic [SW-1:0] n);
        int k;
        logic ew, ef, el, ed;
        int ec, esd;
        start = st;
        abort = ab;
        n_shots = n;
        @(posedge clk);
        e++;
        if (!m_act) begin
            if (st && !ab) begin
                m_act = 1;
                m_tgt = (n == 0) ? 1 : int'(n);
                m_cs = -1;
                m_sd = 0;
            end
        end else if (m_cs < 0) begin
            if (ab) m_act = 0;
            else if (address == P - 1) m_cs = e;
        end else begin
            k = e - 1 - m_cs;
            if (ab || k >= P * m_tgt) begin
                m_act = 0;
                m_sd = k / P;
            end
        end
        #1 address = address + 1'b1;
        start = 0;
        abort = 0;
        @(negedge clk);
        ew = 0; ef = 0; el = 0; ed = 0; ec = 0; esd = m_sd;
        if (m_act && m_cs >= 0) begin
            k = e - m_cs;
            if (k < P * m_tgt) begin
                ew = 1;
                ec = k % P;
                esd = k / P;
                ef = (esd == 0);
                el = (esd == m_tgt - 1);
            end else begin
                ed = 1;
                esd = m_tgt;
            end
        end
        check("wen", wen, ew);
        check("count", count, ec);
        check("first_pass", first_pass, ef);
        check("last_pass", last_pass, el);
        check("busy", busy, m_act);
        check("done", done, ed);
        check("shots_done", shots_done, esd);
        if (ew) check("count_vs_address", count, address);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0);
    endtask

    task automatic run_until_k(input int kk);
        for (int i = 0; i < 300 && !(m_act && m_cs >= 0 && e - m_cs == kk); i++) step(0, 0, 0);
        check("reach_capture_pos", m_act && m_cs >= 0 && e - m_cs == kk, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wen", wen, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_shots_done", shots_done, 0);
        check("rst_first", first_pass, 0);
        check("rst_last", last_pass, 0);
        rst = 0;
        idle(3);
        // Single shot launched when address reads 5
        for (int i = 0; i < 40 && address != 5; i++) step(0, 0, 0);
        check("addr_at_5", address, 5);
        step(1, 0, 1);
        idle(40);
        check("single_shots_done", shots_done, 1);
        // Three back-to-back shots
        step(1, 0, 3);
        idle(80);
        check("multi_shots_done", shots_done, 3);
        // Abort at count 7 of shot 1
        step(1, 0, 3);
        run_until_k(P + 7);
        step(0, 1, 0);
        check("abort_wen", wen, 0);
        check("abort_shots_done", shots_done, 1);
        idle(20);
        // Start while busy is ignored
        step(1, 0, 2);
        run_until_k(5);
        step(1, 0, 9);
        idle(60);
        check("busy_start_shots_done", shots_done, 2);
        // n_shots = 0 yields one pass; start+abort does nothing
        step(1, 0, 0);
        idle(40);
        check("zero_shots_done", shots_done, 1);
        step(1, 1, 5);
        check("start_abort_busy", busy, 0);
        idle(5);
        // Asynchronous reset between edges mid-capture
        step(1, 0, 2);
        run_until_k(20);
        #1 rst = 1;
        #1;
        check("arst_wen", wen, 0);
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        check("arst_shots_done", shots_done, 0);
        #1 rst = 0;
        m_act = 0;
        m_sd = 0;
        step(1, 0, 1);
        idle(40);
        check("post_rst_shots_done", shots_done, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 3, $urandom_range(0, 249) == 0, SW'($urandom_range(0, 5)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
